vs_inner_product_scheduler: RTL and testbench

- Sequences the dictionary processor for the COMPUTE_INNER_PRODUCTS command.
- For every atom j, streams the signal y from the y RAM and atom j from the dictionary RAM, and accumulates the fixed-point inner product.
- Writes each result into the x RAM and reports the atom index with the largest absolute correlation.
- Sits between the pursuit top-level controller and the y, dict and x synchronous RAMs.

---
 rtl/vs_inner_product_scheduler_pkg.sv | 53 +++++
 rtl/vs_fp_mac.sv | 32 +++
 rtl/vs_inner_product_scheduler.sv | 160 ++++++++++++++++
 tb/tb_vs_inner_product_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vs_inner_product_scheduler_pkg.sv
// rtl/vs_inner_product_scheduler_pkg.sv - shared types, widths and fixed-point helpers
package vs_inner_product_scheduler_pkg;

   localparam int SIGNAL_SIZE_DEFAULT       = 16;
   localparam int DICTIONARY_SIZE_DEFAULT   = 64;
   localparam int FP_Q_DEFAULT              = 15;

   localparam int SIGNAL_ADDR_WIDTH         = 8;
   localparam int DICTIONARY_ADDR_WIDTH     = 16;
   localparam int REPRESENTATION_ADDR_WIDTH = 8;
   localparam int FP_DATA_BUS_WIDTH         = 32;

   typedef logic signed [63:0] fp_64_t;
   typedef logic signed [31:0] fp_32_t;

   typedef enum logic [2:0] {
      LOAD_SENSING_MATRIX    = 3'd0,
      COMPUTE_INNER_PRODUCTS = 3'd1,
      UPDATE_RESIDUAL        = 3'd2,
      SOLVE_LEAST_SQUARES    = 3'd3
   } vs_dict_proc_command_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } vs_ip_sched_state_t;

   // Arithmetic shift keeps rounding toward minus infinity for negative sums.
   function automatic fp_32_t vs_sat_fp64_to_fp32(input fp_64_t acc, input int unsigned q);
      fp_64_t s;
      s = acc >>> q;
      if (s > 64'sh0000_0000_7FFF_FFFF)
         return 32'h7FFF_FFFF;
      else if (s < 64'shFFFF_FFFF_8000_0000)
         return 32'h8000_0000;
      else
         return s[31:0];
   endfunction

   function automatic logic [31:0] vs_abs_fp32(input fp_32_t v);
      if (v == 32'sh8000_0000)
         return 32'h7FFF_FFFF;
      else if (v < 0)
         return 32'(-v);
      else
         return 32'(v);
   endfunction

endpackage

// File: rtl/vs_fp_mac.sv
// rtl/vs_fp_mac.sv - registered signed multiply-accumulate with clear and saturated output
module vs_fp_mac
   import vs_inner_product_scheduler_pkg::*;
#(
   parameter int FP_Q = FP_Q_DEFAULT
) (
   input  logic   i_clk,
   input  logic   i_rst_n,
   input  logic   i_clear,
   input  logic   i_en,
   input  fp_32_t i_a,
   input  fp_32_t i_b,
   output fp_32_t o_result
);

   fp_64_t r_acc;
   fp_64_t w_prod;

   assign w_prod = fp_64_t'(i_a) * fp_64_t'(i_b);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_acc <= '0;
      else if (i_clear)
         r_acc <= '0;
      else if (i_en)
         r_acc <= r_acc + w_prod;
   end

   assign o_result = vs_sat_fp64_to_fp32(r_acc, FP_Q);

endmodule

// File: rtl/vs_inner_product_scheduler.sv
// rtl/vs_inner_product_scheduler.sv - streams y and each atom through a MAC, writes x and tracks argmax
module vs_inner_product_scheduler
   import vs_inner_product_scheduler_pkg::*;
#(
   parameter int SIGNAL_SIZE     = SIGNAL_SIZE_DEFAULT,
   parameter int DICTIONARY_SIZE = DICTIONARY_SIZE_DEFAULT,
   parameter int FP_Q            = FP_Q_DEFAULT
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  vs_dict_proc_command_t                command,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 cmd_error,
   output logic [SIGNAL_ADDR_WIDTH-1:0]         y_read_addr,
   input  logic [FP_DATA_BUS_WIDTH-1:0]         y_read_data,
   output logic [DICTIONARY_ADDR_WIDTH-1:0]     dict_read_addr,
   input  logic [FP_DATA_BUS_WIDTH-1:0]         dict_read_data,
   output logic                                 x_write_enable,
   output logic [REPRESENTATION_ADDR_WIDTH-1:0] x_write_addr,
   output logic [FP_DATA_BUS_WIDTH-1:0]         x_write_data,
   output logic [REPRESENTATION_ADDR_WIDTH-1:0] best_index,
   output logic [FP_DATA_BUS_WIDTH-1:0]         best_value
);

   localparam logic [SIGNAL_ADDR_WIDTH-1:0]         LAST_I    = SIGNAL_ADDR_WIDTH'(SIGNAL_SIZE - 1);
   localparam logic [REPRESENTATION_ADDR_WIDTH-1:0] LAST_J    = REPRESENTATION_ADDR_WIDTH'(DICTIONARY_SIZE - 1);
   localparam logic [DICTIONARY_ADDR_WIDTH-1:0]     BASE_STEP = DICTIONARY_ADDR_WIDTH'(SIGNAL_SIZE);

   vs_ip_sched_state_t                   r_state;
   vs_ip_sched_state_t                   w_next;
   logic [SIGNAL_ADDR_WIDTH-1:0]         r_i;
   logic [REPRESENTATION_ADDR_WIDTH-1:0] r_j;
   logic [DICTIONARY_ADDR_WIDTH-1:0]     r_base;
   logic                                 r_rd_valid;
   logic [REPRESENTATION_ADDR_WIDTH-1:0] r_best_index;
   logic [FP_DATA_BUS_WIDTH-1:0]         r_best_value;
   logic [31:0]                          r_best_abs;
   logic                                 w_accept;
   logic                                 w_clear;
   fp_32_t                               w_sat;
   logic [31:0]                          w_abs;

   assign w_accept = (r_state == IDLE) && start && (command == COMPUTE_INNER_PRODUCTS);
   assign w_clear  = w_accept || (r_state == WRITE);
   assign w_abs    = vs_abs_fp32(w_sat);

   vs_fp_mac #(
      .FP_Q     (FP_Q)
   ) u_mac (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_clear  (w_clear),
      .i_en     (r_rd_valid),
      .i_a      (y_read_data),
      .i_b      (dict_read_data),
      .o_result (w_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      busy           = (r_state != IDLE);
      done           = 1'b0;
      cmd_error      = 1'b0;
      x_write_enable = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (command == COMPUTE_INNER_PRODUCTS)
                  w_next = ISSUE;
               else
                  w_next = ERR;
            end
         end
         ISSUE: begin
            if (r_i == LAST_I)
               w_next = DRAIN;
         end
         DRAIN:
            w_next = WRITE;
         WRITE: begin
            x_write_enable = 1'b1;
            if (r_j == LAST_J)
               w_next = DONE;
            else
               w_next = ISSUE;
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         ERR: begin
            cmd_error = 1'b1;
            w_next    = IDLE;
         end
         default:
            w_next = IDLE;
      endcase
   end

   // Counters park on the last address so the RAM addresses hold outside ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_i          <= '0;
         r_j          <= '0;
         r_base       <= '0;
         r_rd_valid   <= 1'b0;
         r_best_index <= '0;
         r_best_value <= '0;
         r_best_abs   <= '0;
      end else begin
         r_rd_valid <= (r_state == ISSUE);
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_i          <= '0;
                  r_j          <= '0;
                  r_base       <= '0;
                  r_best_index <= '0;
                  r_best_value <= '0;
                  r_best_abs   <= '0;
               end
            end
            ISSUE: begin
               if (r_i != LAST_I)
                  r_i <= r_i + 1'b1;
            end
            WRITE: begin
               if ((r_j == '0) || (w_abs > r_best_abs)) begin
                  r_best_index <= r_j;
                  r_best_value <= w_sat;
                  r_best_abs   <= w_abs;
               end
               if (r_j != LAST_J) begin
                  r_j    <= r_j + 1'b1;
                  r_i    <= '0;
                  r_base <= r_base + BASE_STEP;
               end
            end
            default: ;
         endcase
      end
   end

   assign y_read_addr    = r_i;
   assign dict_read_addr = r_base + DICTIONARY_ADDR_WIDTH'(r_i);
   assign x_write_addr   = r_j;
   assign x_write_data   = w_sat;
   assign best_index     = r_best_index;
   assign best_value     = r_best_value;

endmodule

// File: tb/tb_vs_inner_product_scheduler.sv
// tb/tb_vs_inner_product_scheduler.sv - directed table-driven bench for the inner product scheduler
module tb_vs_inner_product_scheduler;
   import vs_inner_product_scheduler_pkg::*;

   localparam int M = 16;
   localparam int N = 64;
   localparam int OP_CYCLES = 1153;

   logic                                 clk = 1'b0;
   logic                                 rst_n;
   logic                                 start;
   vs_dict_proc_command_t                command;
   logic                                 busy;
   logic                                 done;
   logic                                 cmd_error;
   logic [SIGNAL_ADDR_WIDTH-1:0]         y_read_addr;
   logic [FP_DATA_BUS_WIDTH-1:0]         y_read_data;
   logic [DICTIONARY_ADDR_WIDTH-1:0]     dict_read_addr;
   logic [FP_DATA_BUS_WIDTH-1:0]         dict_read_data;
   logic                                 x_write_enable;
   logic [REPRESENTATION_ADDR_WIDTH-1:0] x_write_addr;
   logic [FP_DATA_BUS_WIDTH-1:0]         x_write_data;
   logic [REPRESENTATION_ADDR_WIDTH-1:0] best_index;
   logic [FP_DATA_BUS_WIDTH-1:0]         best_value;

   vs_inner_product_scheduler #(
      .SIGNAL_SIZE     (M),
      .DICTIONARY_SIZE (N),
      .FP_Q            (15)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .command        (command),
      .busy           (busy),
      .done           (done),
      .cmd_error      (cmd_error),
      .y_read_addr    (y_read_addr),
      .y_read_data    (y_read_data),
      .dict_read_addr (dict_read_addr),
      .dict_read_data (dict_read_data),
      .x_write_enable (x_write_enable),
      .x_write_addr   (x_write_addr),
      .x_write_data   (x_write_data),
      .best_index     (best_index),
      .best_value     (best_value)
   );

   always #5 clk = ~clk;

   logic [31:0] y_mem    [M];
   logic [31:0] dict_mem [M*N];
   logic [31:0] x_mem    [N];
   int          x_run    [N];
   int          wr_count = 0;
   int          run_id   = 0;

   always @(posedge clk) begin
      y_read_data    <= y_mem[y_read_addr[3:0]];
      dict_read_data <= dict_mem[dict_read_addr[9:0]];
      if (x_write_enable) begin
         x_mem[x_write_addr[5:0]] <= x_write_data;
         x_run[x_write_addr[5:0]] <= run_id;
         wr_count <= wr_count + 1;
      end
   end

   typedef struct {
      logic [31:0] y_val;
      logic [31:0] fill;
      int          idx_a;
      logic [31:0] val_a;
      int          idx_b;
      logic [31:0] val_b;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [31:0] exp_other;
      int          exp_idx;
      logic [31:0] exp_val;
   } vec_t;

   vec_t vecs [6];

   int checks = 0;
   int errors = 0;
   int op_done_cyc, op_done_cnt, op_busy_cnt, op_err_cnt, op_err_cyc, op_writes;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic load_mem(input vec_t v);
      for (int i = 0; i < M; i++) y_mem[i] = v.y_val;
      for (int j = 0; j < N; j++)
         for (int i = 0; i < M; i++)
            dict_mem[j*M+i] = (j == v.idx_a) ? v.val_a : (j == v.idx_b) ? v.val_b : v.fill;
   endtask

   // Pulses start for one cycle, then observes `limit` cycles; cycle 1 is the one after the start cycle.
   task automatic run_op(input vs_dict_proc_command_t cmd, input int limit, input int glitch_at);
      int w0;
      run_id = run_id + 1;
      op_done_cyc = -1; op_done_cnt = 0; op_busy_cnt = 0; op_err_cnt = 0; op_err_cyc = -1;
      @(negedge clk);
      w0 = wr_count;
      start = 1'b1;
      command = cmd;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         @(negedge clk);
         if (done) begin
            op_done_cnt++;
            if (op_done_cyc < 0) op_done_cyc = cyc;
         end
         if (busy) op_busy_cnt++;
         if (cmd_error) begin
            op_err_cnt++;
            if (op_err_cyc < 0) op_err_cyc = cyc;
         end
         start = 1'b0;
         if (cyc == glitch_at) begin
            start = 1'b1;
            command = COMPUTE_INNER_PRODUCTS;
         end
      end
      start = 1'b0;
      op_writes = wr_count - w0;
   endtask

   task automatic check_vec(input vec_t v, input string tag);
      int bad;
      logic [31:0] e;
      bad = 0;
      for (int j = 0; j < N; j++) begin
         e = (j == v.idx_a) ? v.exp_a : (j == v.idx_b) ? v.exp_b : v.exp_other;
         if (x_run[j] != run_id || x_mem[j] !== e) bad++;
      end
      chk({tag, "_done_cycle"}, op_done_cyc, OP_CYCLES);
      chk({tag, "_done_count"}, op_done_cnt, 1);
      chk({tag, "_busy_cycles"}, op_busy_cnt, OP_CYCLES);
      chk({tag, "_writes"}, op_writes, N);
      chk({tag, "_x_table_bad"}, bad, 0);
      chk({tag, "_x_a"}, x_mem[v.idx_a], v.exp_a);
      chk({tag, "_x_b"}, x_mem[v.idx_b], v.exp_b);
      chk({tag, "_best_index"}, best_index, v.exp_idx);
      chk({tag, "_best_value"}, best_value, v.exp_val);
      chk({tag, "_y_addr_hold"}, y_read_addr, M-1);
      chk({tag, "_dict_addr_hold"}, dict_read_addr, M*N-1);
   endtask

   initial begin
      //           y_val          fill           a   val_a          b   val_b          exp_a          exp_b          exp_other      idx exp_val
      vecs[0] = '{32'h0000_2000, 32'h0000_0000, 5,  32'h0000_2000, 5,  32'h0000_2000, 32'h0000_8000, 32'h0000_8000, 32'h0000_0000, 5,  32'h0000_8000};
      vecs[1] = '{32'h0000_2000, 32'h0000_0000, 9,  32'hFFFF_A000, 5,  32'h0000_2000, 32'hFFFE_8000, 32'h0000_8000, 32'h0000_0000, 9,  32'hFFFE_8000};
      vecs[2] = '{32'h0000_2000, 32'h0000_0000, 3,  32'h0000_2000, 7,  32'h0000_2000, 32'h0000_8000, 32'h0000_8000, 32'h0000_0000, 3,  32'h0000_8000};
      vecs[3] = '{32'h0032_0000, 32'h0032_0000, 0,  32'h0032_0000, 63, 32'h0032_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0,  32'h7FFF_FFFF};
      vecs[4] = '{32'h0032_0000, 32'hFFCE_0000, 0,  32'hFFCE_0000, 1,  32'hFFCE_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0,  32'h8000_0000};
      vecs[5] = '{32'h0000_0001, 32'h0000_0000, 10, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 10, 32'hFFFF_FFFF};

      rst_n = 1'b0;
      start = 1'b0;
      command = LOAD_SENSING_MATRIX;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_x_we", x_write_enable, 0);
      chk("reset_y_addr", y_read_addr, 0);
      chk("reset_dict_addr", dict_read_addr, 0);
      chk("reset_best_index", best_index, 0);
      chk("reset_best_value", best_value, 0);

      for (int v = 0; v < 6; v++) begin
         load_mem(vecs[v]);
         run_op(COMPUTE_INNER_PRODUCTS, OP_CYCLES + 7, 0);
         check_vec(vecs[v], $sformatf("vec%0d", v));
         chk($sformatf("vec%0d_busy_after", v), busy, 0);
      end

      run_op(LOAD_SENSING_MATRIX, 8, 0);
      chk("err_cycle", op_err_cyc, 1);
      chk("err_count", op_err_cnt, 1);
      chk("err_busy_cycles", op_busy_cnt, 1);
      chk("err_writes", op_writes, 0);
      chk("err_done_count", op_done_cnt, 0);
      chk("err_best_hold", best_index, 10);

      load_mem(vecs[1]);
      run_op(COMPUTE_INNER_PRODUCTS, 1300, 100);
      chk("glitch_done_count", op_done_cnt, 1);
      chk("glitch_done_cycle", op_done_cyc, OP_CYCLES);
      chk("glitch_busy_cycles", op_busy_cnt, OP_CYCLES);
      chk("glitch_best_index", best_index, 9);

      load_mem(vecs[0]);
      run_op(COMPUTE_INNER_PRODUCTS, 20*(M+2) + 5, 0);
      chk("rst_writes_before", op_writes, 20);
      rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_x_we", x_write_enable, 0);
      chk("rst_x_data", x_write_data, 0);
      chk("rst_x_addr", x_write_addr, 0);
      chk("rst_y_addr", y_read_addr, 0);
      chk("rst_dict_addr", dict_read_addr, 0);
      chk("rst_best_index", best_index, 0);
      chk("rst_best_value", best_value, 0);
      begin
         int w0;
         w0 = wr_count;
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         repeat (30) @(negedge clk);
         chk("rst_no_writes", wr_count - w0, 0);
         chk("rst_idle_busy", busy, 0);
      end
      run_op(COMPUTE_INNER_PRODUCTS, OP_CYCLES + 7, 0);
      check_vec(vecs[0], "rerun");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
